// File: rtl/jamma_input_scanner_pkg.sv
// Shared definitions for the JAMMA input scanner: scan FSM states, the
// inactive (released) input level and debounce counter sizing.
package jamma_input_scanner_pkg;

   typedef enum logic [1:0] {
      ST_SETTLE  = 2'd0,
      ST_SAMPLE  = 2'd1,
      ST_ADVANCE = 2'd2
   } scan_state_t;

   localparam logic INACTIVE_LEVEL = 1'b1;
   localparam int   SETTLE_CNT_W   = 4;

   // The counter only ever reaches DEB_CNT-1 before flipping or clearing.
   function automatic int deb_cnt_width(input int deb_cnt);
      return (deb_cnt <= 2) ? 1 : $clog2(deb_cnt);
   endfunction

endpackage

// File: rtl/jamma_input_scanner_debounce.sv
// Per-channel debouncer: a bit flips only after DEB_CNT consecutive samples
// that differ from the stable level; DEB_CNT=0 passes samples straight through.
module jamma_debounce_word
   import jamma_input_scanner_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEB_CNT = 3
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             update,
   input  logic [WIDTH-1:0] sample,
   output logic [WIDTH-1:0] stable,
   output logic             flip
);

   logic [WIDTH-1:0] flip_bits;

   if (DEB_CNT == 0) begin : g_bypass
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            stable <= {WIDTH{INACTIVE_LEVEL}};
         else if (update)
            stable <= sample;
      end

      assign flip_bits = update ? (sample ^ stable) : '0;
   end else begin : g_deb
      localparam int              CNT_W   = deb_cnt_width(DEB_CNT);
      localparam logic [CNT_W:0]  TARGET  = (CNT_W+1)'(DEB_CNT);
      localparam logic [CNT_W-1:0] CNT_MAX = '1;

      logic [CNT_W-1:0] cnt [WIDTH];

      always_comb begin
         flip_bits = '0;
         for (int b = 0; b < WIDTH; b++) begin
            if (update && (sample[b] != stable[b]) &&
                (({1'b0, cnt[b]} + (CNT_W+1)'(1)) == TARGET))
               flip_bits[b] = 1'b1;
         end
      end

      // Agreement with the stable level restarts the run; the counter saturates.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stable <= {WIDTH{INACTIVE_LEVEL}};
            for (int b = 0; b < WIDTH; b++)
               cnt[b] <= '0;
         end else if (update) begin
            for (int b = 0; b < WIDTH; b++) begin
               if (sample[b] == stable[b]) begin
                  cnt[b] <= '0;
               end else if (flip_bits[b]) begin
                  stable[b] <= ~stable[b];
                  cnt[b]    <= '0;
               end else if (cnt[b] != CNT_MAX) begin
                  cnt[b] <= cnt[b] + CNT_W'(1);
               end
            end
         end
      end
   end

   assign flip = |flip_bits;

endmodule

// File: rtl/jamma_input_scanner.sv
// JAMMA control-input scanner: steps the external mux select, settles, samples
// the shared active-low bus and debounces one stable word per channel.
module jamma_input_scanner
   import jamma_input_scanner_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int WIDTH   = 8,
   parameter int SETTLE  = 2,
   parameter int DEB_CNT = 3,
   parameter int SEL_W   = 3
)(
   input  logic                    I_CLK,
   input  logic                    I_RESET_N,
   input  logic                    I_ENA,
   input  logic [WIDTH-1:0]        I_JJOY,
   input  logic [WIDTH-1:0]        I_LOCAL,
   output logic [SEL_W-1:0]        O_JSELECT,
   output logic [NUM_CH*WIDTH-1:0] O_JOY,
   output logic                    O_SCAN_DONE,
   output logic                    O_CHANGED
);

   localparam logic [SEL_W-1:0]      LAST_CH      = SEL_W'(NUM_CH - 1);
   localparam logic [SETTLE_CNT_W:0] SETTLE_TICKS = (SETTLE_CNT_W+1)'(SETTLE);

   scan_state_t              state_q, state_d;
   logic [SETTLE_CNT_W-1:0]  settle_cnt;
   logic                     settle_done;
   logic                     sample_en;
   logic [SEL_W-1:0]         sel;
   logic [WIDTH-1:0]         jjoy_meta, jjoy_sync;
   logic [WIDTH-1:0]         raw_word;
   logic [WIDTH-1:0]         ch_word [NUM_CH];
   logic [NUM_CH-1:0]        ch_flip;
   logic                     scan_flip;

   // Connector bus is asynchronous to the core, so it is synchronised every clock.
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         jjoy_meta <= {WIDTH{INACTIVE_LEVEL}};
         jjoy_sync <= {WIDTH{INACTIVE_LEVEL}};
      end else begin
         jjoy_meta <= I_JJOY;
         jjoy_sync <= jjoy_meta;
      end
   end

   assign settle_done = ({1'b0, settle_cnt} + (SETTLE_CNT_W+1)'(1)) >= SETTLE_TICKS;

   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N)
         state_q <= ST_SETTLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      sample_en = 1'b0;
      if (I_ENA) begin
         case (state_q)
            ST_SETTLE:  if (settle_done) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
               sample_en = 1'b1;
               state_d   = ST_ADVANCE;
            end
            ST_ADVANCE: state_d = ST_SETTLE;
            default:    state_d = ST_SETTLE;
         endcase
      end
   end

   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         settle_cnt <= '0;
         sel        <= '0;
      end else if (I_ENA) begin
         if (state_q == ST_SETTLE && settle_cnt != '1)
            settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
         if (state_q == ST_ADVANCE) begin
            settle_cnt <= '0;
            sel        <= (sel == LAST_CH) ? '0 : sel + SEL_W'(1);
         end
      end
   end

   assign O_JSELECT = sel;

   // On-board buttons share channel 0 with the connector's first bank.
   assign raw_word = jjoy_sync & ((sel == '0) ? I_LOCAL : {WIDTH{INACTIVE_LEVEL}});

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic ch_update;
      assign ch_update = sample_en && (sel == SEL_W'(c));

      jamma_debounce_word #(
         .WIDTH   (WIDTH),
         .DEB_CNT (DEB_CNT)
      ) u_deb (
         .clk    (I_CLK),
         .rst_n  (I_RESET_N),
         .update (ch_update),
         .sample (raw_word),
         .stable (ch_word[c]),
         .flip   (ch_flip[c])
      );
   end

   always_comb begin
      O_JOY = '0;
      for (int c = 0; c < NUM_CH; c++)
         O_JOY[c*WIDTH +: WIDTH] = ch_word[c];
   end

   // Flips are accumulated across the scan and reported with the last channel's commit.
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         scan_flip   <= 1'b0;
         O_SCAN_DONE <= 1'b0;
         O_CHANGED   <= 1'b0;
      end else begin
         O_SCAN_DONE <= 1'b0;
         O_CHANGED   <= 1'b0;
         if (sample_en) begin
            if (sel == LAST_CH) begin
               O_SCAN_DONE <= 1'b1;
               O_CHANGED   <= scan_flip | (|ch_flip);
               scan_flip   <= 1'b0;
            end else begin
               scan_flip <= scan_flip | (|ch_flip);
            end
         end
      end
   end

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Self-checking bench for jamma_input_scanner: directed and randomised steps
// compared each clock against a tick-counting reference model of the scan.
module tb_jamma_input_scanner;

   localparam int NUM_CH  = 2;
   localparam int WIDTH   = 8;
   localparam int SETTLE  = 2;
   localparam int DEB_CNT = 3;
   localparam int SEL_W   = 3;
   localparam int TICKS_PER_CH = SETTLE + 2;

   logic                    clk;
   logic                    rst_n;
   logic                    ena;
   logic [WIDTH-1:0]        jjoy;
   logic [WIDTH-1:0]        local_in;
   logic [SEL_W-1:0]        jsel;
   logic [NUM_CH*WIDTH-1:0] joy;
   logic                    done;
   logic                    changed;

   int checks;
   int failures;

   jamma_input_scanner #(
      .NUM_CH  (NUM_CH),
      .WIDTH   (WIDTH),
      .SETTLE  (SETTLE),
      .DEB_CNT (DEB_CNT),
      .SEL_W   (SEL_W)
   ) dut (
      .I_CLK       (clk),
      .I_RESET_N   (rst_n),
      .I_ENA       (ena),
      .I_JJOY      (jjoy),
      .I_LOCAL     (local_in),
      .O_JSELECT   (jsel),
      .O_JOY       (joy),
      .O_SCAN_DONE (done),
      .O_CHANGED   (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: position in the scan is derived from the count of enable ticks.
   int               tick_n;
   logic [WIDTH-1:0] m_stable [NUM_CH];
   int               m_run [NUM_CH][WIDTH];
   logic [WIDTH-1:0] bus_hist [2];
   bit               scan_flip;
   bit               exp_done;
   bit               exp_chg;
   logic [WIDTH-1:0] bus_v;
   logic [WIDTH-1:0] loc_v;
   bit               ena_v;

   function automatic int cur_ch();
      return (tick_n / TICKS_PER_CH) % NUM_CH;
   endfunction

   function automatic int cur_phase();
      return tick_n % TICKS_PER_CH;
   endfunction

   task automatic modelReset();
      tick_n    = 0;
      scan_flip = 1'b0;
      exp_done  = 1'b0;
      exp_chg   = 1'b0;
      bus_hist[0] = '1;
      bus_hist[1] = '1;
      for (int c = 0; c < NUM_CH; c++) begin
         m_stable[c] = '1;
         for (int b = 0; b < WIDTH; b++)
            m_run[c][b] = 0;
      end
   endtask

   task automatic modelEdge(input bit e, input logic [WIDTH-1:0] bus, input logic [WIDTH-1:0] loc);
      logic [WIDTH-1:0] raw;
      bit               flip_now;
      int               ch;
      exp_done = 1'b0;
      exp_chg  = 1'b0;
      if (e) begin
         if (cur_phase() == SETTLE) begin
            ch       = cur_ch();
            raw      = bus_hist[1] & ((ch == 0) ? loc : '1);
            flip_now = 1'b0;
            for (int b = 0; b < WIDTH; b++) begin
               if (raw[b] == m_stable[ch][b]) begin
                  m_run[ch][b] = 0;
               end else begin
                  m_run[ch][b] = m_run[ch][b] + 1;
                  if (m_run[ch][b] == DEB_CNT) begin
                     m_stable[ch][b] = raw[b];
                     m_run[ch][b]    = 0;
                     flip_now        = 1'b1;
                  end
               end
            end
            if (ch == NUM_CH - 1) begin
               exp_done  = 1'b1;
               exp_chg   = scan_flip | flip_now;
               scan_flip = 1'b0;
            end else begin
               scan_flip = scan_flip | flip_now;
            end
         end
         tick_n = tick_n + 1;
      end
      bus_hist[1] = bus_hist[0];
      bus_hist[0] = bus;
   endtask

   task automatic compareVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         failures = failures + 1;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      logic [NUM_CH*WIDTH-1:0] exp_joy;
      for (int c = 0; c < NUM_CH; c++)
         exp_joy[c*WIDTH +: WIDTH] = m_stable[c];
      compareVal("jselect", 16'(jsel), 16'(cur_ch()));
      compareVal("joy", 16'(joy), 16'(exp_joy));
      compareVal("scan_done", 16'(done), 16'(exp_done));
      compareVal("changed", 16'(changed), 16'(exp_chg));
   endtask

   task automatic applyStimulus(input bit e, input logic [WIDTH-1:0] bus, input logic [WIDTH-1:0] loc);
      @(negedge clk);
      ena      = e;
      jjoy     = bus;
      local_in = loc;
      @(posedge clk);
      modelEdge(e, bus, loc);
      #1;
      checkOutput();
   endtask

   // Reset is asserted between clock edges and must act without waiting for one.
   task automatic applyReset();
      #2;
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput();
      compareVal("rst_joy", 16'(joy), 16'hFFFF);
      compareVal("rst_jselect", 16'(jsel), 16'h0000);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      ena      = 1'b0;
      jjoy     = '1;
      local_in = '1;
      modelReset();
      #1;
      applyReset();

      $display("[TB] idle bus, select cycling");
      for (int i = 0; i < 24; i++)
         applyStimulus(1'b1, 8'hFF, 8'hFF);

      $display("[TB] bit0 low on channel 1 only");
      for (int i = 0; i < 48; i++)
         applyStimulus(1'b1, (cur_ch() == 1) ? 8'hFE : 8'hFF, 8'hFF);

      $display("[TB] two-sample glitch on channel 0");
      for (int i = 0; i < 16; i++)
         applyStimulus(1'b1, (cur_ch() == 0) ? 8'hFE : 8'hFF, 8'hFF);
      for (int i = 0; i < 32; i++)
         applyStimulus(1'b1, 8'hFF, 8'hFF);

      $display("[TB] local inputs on channel 0");
      for (int i = 0; i < 48; i++)
         applyStimulus(1'b1, 8'hFF, 8'hDF);

      $display("[TB] enable 1-in-4 then reset during channel 1 settle");
      for (int i = 0; i < 96; i++)
         applyStimulus((i % 4) == 0, 8'hFF, 8'hDF);
      for (int i = 0; i < 64; i++) begin
         if (cur_ch() == 1 && cur_phase() < SETTLE)
            break;
         applyStimulus((i % 4) == 0, 8'hFF, 8'hDF);
      end
      compareVal("pre_reset_sel", 16'(jsel), 16'h0001);
      applyReset();

      $display("[TB] randomised bus and enable");
      bus_v = '1;
      loc_v = '1;
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 5) == 0)
            bus_v = 8'($urandom) | 8'($urandom);
         if ($urandom_range(0, 40) == 0)
            loc_v = 8'($urandom) | 8'($urandom) | 8'($urandom);
         ena_v = ($urandom_range(0, 3) != 0);
         applyStimulus(ena_v, bus_v, loc_v);
         if (i == 600)
            applyReset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
